// File: rtl/accum_decoder_bank.sv
// accum_decoder_bank
//   A bank of CHANNELS = 2**SEL_W registered accumulators, each WIDTH bits wide.
//   The block accepts one operation per handshake and registers its result one
//   cycle after the accept edge. The result comes with a carry, a one-hot channel
//   decode and even/odd channel flags.
//
// Operations (mode):
//   2'b00 LOAD      acc[sel] <= op1 + op2
//   2'b01 ADD       acc[sel] <= acc[sel] + op1   (op2 ignored)
//   2'b10 CLEAR     acc[sel] <= 0
//   2'b11 CLEAR_ALL sweeps every channel to 0, one channel per cycle
//
// Build option:
//   SATURATE_EN  When defined, LOAD/ADD results that overflow clamp to
//                2**WIDTH-1, and out_carry still reports the overflow.
//                When undefined, results wrap modulo 2**WIDTH.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operation request
//   in_ready   block can accept an operation (low while rst or sweeping)
//   mode       operation code (see above)
//   sel        target channel (ignored for CLEAR_ALL)
//   op1, op2   operands
//   out_valid  one-cycle result strobe
//   out_sum    value written to the channel (held between strobes)
//   out_carry  unsigned overflow of the operation (held between strobes)
//   dec_out    one-hot channel of the last result; all ones after CLEAR_ALL
//   out_even   OR of the even-index bits of dec_out
//   out_odd    OR of the odd-index bits of dec_out
module accum_decoder_bank #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [WIDTH-1:0]        op1,
  input  logic [WIDTH-1:0]        op2,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_sum,
  output logic                    out_carry,
  output logic [(2**SEL_W)-1:0]   dec_out,
  output logic                    out_even,
  output logic                    out_odd
);

  localparam int CHANNELS = 2 ** SEL_W;

  localparam logic [1:0] MODE_LOAD      = 2'b00;
  localparam logic [1:0] MODE_ADD       = 2'b01;
  localparam logic [1:0] MODE_CLEAR     = 2'b10;
  localparam logic [1:0] MODE_CLEAR_ALL = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [SEL_W-1:0]      sweep_k_r;
  logic                  sweep_last_s;
  logic                  accept_s;

  logic [WIDTH-1:0]      acc_r [CHANNELS];

  // Accepted single-channel operation waiting to execute on the next edge.
  logic                  pend_valid_r;
  logic [1:0]            pend_mode_r;
  logic [SEL_W-1:0]      pend_sel_r;
  logic [WIDTH-1:0]      pend_op1_r;
  logic [WIDTH-1:0]      pend_op2_r;

  logic [WIDTH:0]        exec_sum_s;
  logic [WIDTH-1:0]      exec_res_s;

  logic                  out_valid_r;
  logic [WIDTH-1:0]      out_sum_r;
  logic                  out_carry_r;
  logic [CHANNELS-1:0]   dec_out_r;

  assign accept_s     = in_valid && in_ready;
  assign sweep_last_s = (sweep_k_r == SEL_W'(CHANNELS - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic: CLEAR_ALL starts a sweep that ends after the last channel.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (mode == MODE_CLEAR_ALL)) begin
          state_s = ST_SWEEP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (sweep_last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SWEEP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE and never while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      ST_IDLE:  in_ready = !rst;
      ST_SWEEP: in_ready = 1'b0;
      default:  in_ready = 1'b0;
    endcase
  end

  // Sweep counter: walks channel 0..CHANNELS-1 while sweeping, wraps back to 0 at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_k_r <= {SEL_W{1'b0}};
    end else if (state_r == ST_SWEEP) begin
      sweep_k_r <= sweep_k_r + {{(SEL_W-1){1'b0}}, 1'b1};
    end else begin
      sweep_k_r <= {SEL_W{1'b0}};
    end
  end

  // Capture an accepted LOAD/ADD/CLEAR so that it executes on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_r <= 1'b0;
      pend_mode_r  <= MODE_LOAD;
      pend_sel_r   <= {SEL_W{1'b0}};
      pend_op1_r   <= {WIDTH{1'b0}};
      pend_op2_r   <= {WIDTH{1'b0}};
    end else begin
      pend_valid_r <= accept_s && (mode != MODE_CLEAR_ALL);
      if (accept_s) begin
        pend_mode_r <= mode;
        pend_sel_r  <= sel;
        pend_op1_r  <= op1;
        pend_op2_r  <= op2;
      end
    end
  end

  // Datapath: a WIDTH+1 bit sum whose top bit is the carry.
  always_comb begin
    exec_sum_s = {(WIDTH+1){1'b0}};
    case (pend_mode_r)
      MODE_LOAD:  exec_sum_s = {1'b0, pend_op1_r} + {1'b0, pend_op2_r};
      MODE_ADD:   exec_sum_s = {1'b0, acc_r[pend_sel_r]} + {1'b0, pend_op1_r};
      MODE_CLEAR: exec_sum_s = {(WIDTH+1){1'b0}};
      default:    exec_sum_s = {(WIDTH+1){1'b0}};
    endcase
  end

  // Result value: wrap or clamp depending on the build option.
  always_comb begin
    exec_res_s = exec_sum_s[WIDTH-1:0];
`ifdef SATURATE_EN
    if (exec_sum_s[WIDTH]) begin
      exec_res_s = {WIDTH{1'b1}};
    end else begin
      exec_res_s = exec_sum_s[WIDTH-1:0];
    end
`else
    exec_res_s = exec_sum_s[WIDTH-1:0];
`endif
  end

  // Accumulator bank. The sweep and a pending operation never overlap, because
  // the CLEAR_ALL accept edge leaves nothing pending and nothing is accepted while sweeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_r[i] <= {WIDTH{1'b0}};
      end
    end else if (state_r == ST_SWEEP) begin
      acc_r[sweep_k_r] <= {WIDTH{1'b0}};
    end else if (pend_valid_r) begin
      acc_r[pend_sel_r] <= exec_res_s;
    end
  end

  // Result registers: a strobe for each executed operation or sweep completion; values hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= {WIDTH{1'b0}};
      out_carry_r <= 1'b0;
      dec_out_r   <= {CHANNELS{1'b0}};
    end else begin
      out_valid_r <= 1'b0;
      if (pend_valid_r) begin
        out_valid_r <= 1'b1;
        out_sum_r   <= exec_res_s;
        out_carry_r <= exec_sum_s[WIDTH];
        dec_out_r   <= {{(CHANNELS-1){1'b0}}, 1'b1} << pend_sel_r;
      end else if ((state_r == ST_SWEEP) && sweep_last_s) begin
        out_valid_r <= 1'b1;
        out_sum_r   <= {WIDTH{1'b0}};
        out_carry_r <= 1'b0;
        dec_out_r   <= {CHANNELS{1'b1}};
      end
    end
  end

  // Even/odd channel flags derived from the registered decode.
  always_comb begin
    out_even = 1'b0;
    out_odd  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((i % 2) == 0) begin
        out_even = out_even | dec_out_r[i];
      end else begin
        out_odd = out_odd | dec_out_r[i];
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_carry = out_carry_r;
  assign dec_out   = dec_out_r;

endmodule

// File: doc/accum_decoder_bank.md
Name: accum_decoder_bank

Overview:
Parametrised successor to the team's combinational adder/decoder example block. It holds a bank of 2**SEL_W registered accumulators of WIDTH bits and performs load, add, clear and clear-all operations under a valid/ready handshake. Each result is registered one cycle later, together with the carry, a one-hot decode of the channel and even/odd channel flags. It sits as a small datapath unit behind a controller or bench that issues one operation at a time.

Parameters:
WIDTH, 4, operand/accumulator width in bits (>=2)
SEL_W, 2, channel-select width; CHANNELS = 2**SEL_W (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation
mode  input  2  00 LOAD, 01 ADD, 10 CLEAR, 11 CLEAR_ALL
sel  input  SEL_W  target channel
op1  input  WIDTH  operand 1
op2  input  WIDTH  operand 2
out_valid  output  1  one-cycle result strobe
out_sum  output  WIDTH  result written to channel
out_carry  output  1  unsigned overflow of the operation
dec_out  output  CHANNELS  one-hot channel of last result; all ones after CLEAR_ALL
out_even  output  1  OR of dec_out even-index bits
out_odd  output  1  OR of dec_out odd-index bits

Behaviour:
- One clock, synchronous active-high reset. While rst=1 at an edge: all accumulators=0, out_valid=0, out_sum=0, out_carry=0, dec_out=0, FSM=IDLE. in_ready is 0 while rst is high.
- Accept: in_valid && in_ready at edge t. The result is registered at edge t+1: out_valid=1 for exactly one cycle; out_sum, out_carry and dec_out update at the same edge. out_sum, out_carry and dec_out hold between strobes. There is no output backpressure.
- in_valid while in_ready=0 is ignored: no state change and no strobe.
- FSM states: IDLE (in_ready=1) and SWEEP (in_ready=0).
- LOAD: s = op1 + op2, computed at WIDTH+1 bits. acc[sel] <= s[WIDTH-1:0]; out_carry = s[WIDTH].
- ADD: s = acc[sel] + op1, computed at WIDTH+1 bits; op2 is ignored. acc[sel] <= s[WIDTH-1:0]; out_carry = s[WIDTH].
- CLEAR: acc[sel] <= 0; out_sum=0, out_carry=0.
- LOAD, ADD and CLEAR are single-cycle in IDLE and allow back-to-back accepts every cycle. dec_out = 1 << sel.
- out_even and out_odd are combinational from dec_out.
- CLEAR_ALL: the accept edge moves the FSM IDLE->SWEEP.
  - In SWEEP, an internal counter k = 0..CHANNELS-1 clears acc[k], one channel per cycle.
  - After acc[CHANNELS-1] is cleared: FSM returns to IDLE and out_valid pulses with out_sum=0, out_carry=0, dec_out=all ones.
  - in_ready is low for exactly CHANNELS cycles after the accept edge.
- Reset during SWEEP: the next edge forces IDLE, counter=0 and all accumulators=0. No completion strobe is issued.
- sel is ignored for CLEAR_ALL.
- Channels never interact. Wrap-around is modulo 2**WIDTH unless the optional feature is compiled in.

Optional Feature:
Macro SATURATE_EN.
- Defined: LOAD/ADD results clamp to 2**WIDTH-1 whenever s[WIDTH]=1; the clamped value is stored and output, and out_carry still reports 1.
- Undefined: results wrap modulo 2**WIDTH; out_carry reports the overflow.

Test Plan:
All scenarios use WIDTH=4, SEL_W=2.
1. Reset, then LOAD sel=2 op1=3 op2=5 -> one cycle later out_valid=1, out_sum=8, out_carry=0, dec_out=0100, out_even=1, out_odd=0.
2. After scenario 1, ADD sel=2 op1=9 -> out_sum=1, out_carry=1 (wrap). With SATURATE_EN: out_sum=15, out_carry=1. A further ADD sel=2 op1=0 returns the stored value (1 or 15 respectively).
3. LOAD sel=3 op1=15 op2=15 -> out_sum=14, out_carry=1, dec_out=1000, out_odd=1. CLEAR sel=3, then ADD sel=3 op1=0 -> out_sum=0.
4. LOAD 7 into each channel, then CLEAR_ALL -> in_ready=0 for 4 cycles and in_valid pulses during that window are ignored. Strobe shows out_sum=0, dec_out=1111. ADD op1=0 on each channel then returns 0.
5. CLEAR_ALL, then assert rst for one cycle at the second SWEEP cycle -> no completion strobe; after rst releases, in_ready=1 and all channels read 0.
6. Back-to-back LOAD sel=0..3 with op1=i, op2=1 on consecutive cycles -> four consecutive strobes with out_sum=1,2,3,4 and dec_out=0001,0010,0100,1000.
